fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, shall be the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, shall be the PC increment per fetched instruction.
REQ-003 clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  shall be asynchronous, active-low; 0 resets the block.
REQ-005 redirect_valid  input  1  shall request a PC change (branch/jump) this cycle.
REQ-006 redirect_pc  input  32  shall be the redirect target; bits [1:0] are treated as 0.
REQ-007 imem_req  output  1  shall flag a valid instruction-memory read request.
REQ-008 imem_addr  output  32  shall be the read address, equal to pc.
REQ-009 imem_gnt  input  1  shall signal memory acceptance of the request this cycle.
REQ-010 imem_rvalid  input  1  shall signal that imem_rdata is valid this cycle.
REQ-011 imem_rdata  input  32  shall be the returned instruction word.
REQ-012 instr_valid  output  1  shall flag a valid instruction toward decode.
REQ-013 instr_out  output  32  shall be the fetched instruction.
REQ-014 instr_pc  output  32  shall be the address instr_out was fetched from.
REQ-015 instr_ready  input  1  shall signal decode accepts instr_out this cycle.
REQ-016 pc  output  32  shall be the current fetch PC.
REQ-017 fetch_count  output  16  shall count delivered instructions, wrapping at 16'hFFFF.

Function
REQ-018 The FSM shall have states IDLE, REQ, WAIT, KILL, HOLD; one request outstanding maximum.
REQ-019 IDLE shall last exactly one cycle after reset release, then go to REQ.
REQ-020 REQ: imem_req=1, imem_addr=pc held stable until imem_gnt; on gnt -> WAIT.
REQ-021 WAIT: on imem_rvalid, capture imem_rdata and pc into instr_out/instr_pc, pc <= pc+PC_STEP (mod 2^32), -> HOLD.
REQ-022 HOLD: instr_valid=1 with instr_out/instr_pc stable; on instr_ready, fetch_count+1 -> REQ.
REQ-023 instr_valid shall rise the cycle after imem_rvalid is sampled; minimum 3 cycles per instruction.
REQ-024 redirect_valid shall load pc <= {redirect_pc[31:2],2'b00} in any non-IDLE state and override all increments.
REQ-025 Redirect in REQ without gnt -> REQ with new address next cycle; with gnt -> KILL.
REQ-026 Redirect in WAIT without rvalid -> KILL; with rvalid -> response discarded, -> REQ.
REQ-027 KILL: imem_req=0; on imem_rvalid discard data -> REQ; further redirects only update pc.
REQ-028 Redirect in HOLD shall drop the held instruction (instr_valid=0 next cycle, no count), -> REQ, even if instr_ready=1.
REQ-029 Redirect in IDLE shall be ignored.
REQ-030 imem_rvalid outside WAIT/KILL shall be ignored.

Reset
REQ-031 On reset=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, fetch_count=0, immediately and asynchronously.
REQ-032 Reset asserted mid-transaction shall abandon it; no response arriving afterwards shall be delivered.

Structure
REQ-033 Package fetch_pkg shall hold the state enum, XLEN=32 and the PC_STEP default.
REQ-034 One sub-module pc_reg (async active-low reset, load, increment) shall hold pc; FSM and output registers stay in fetch_sequencer.

Verification
REQ-035 Reset, gnt=1 always, rvalid one cycle after gnt, ready=1 -> instr_pc 0,4,8,12 with matching rdata; fetch_count=4.
REQ-036 ready=0 for 5 cycles in HOLD -> instr_out/instr_pc stable, pc=4, fetch_count unchanged; then 1 accept.
REQ-037 Redirect to 32'd128 in WAIT before rvalid -> stale rdata never on instr_out; next imem_addr=128; instr_pc=128.
REQ-038 Redirect to 32'h83 in HOLD with ready=1 -> instr dropped, count unchanged, next imem_addr=32'h80.
REQ-039 pc=32'hFFFF_FFFC fetched -> next imem_addr=0 (wrap).
REQ-040 reset=0 mid-WAIT, rvalid during reset -> all outputs at reset values, first post-reset address=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int XLEN            = 32;
  localparam int PC_STEP_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_KILL,
    ST_HOLD
  } state_e;

  // Redirect targets are word aligned: the two low address bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: asynchronous reset, load (priority) and increment.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next PC: a load always wins over an increment; the add wraps modulo 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + STEP;
    end
  end

  // PC state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request, redirect
// handling with response killing, and a held output toward decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic [15:0]     fetch_count
);

  state_e          state_q;
  logic            req_q;
  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] ipc_q;
  logic [15:0]     count_q;

  logic            pc_load;
  logic            pc_inc;
  logic [XLEN-1:0] pc_cur;

  // Redirects apply in every state except IDLE; the PC only advances on an
  // accepted (not redirected) response in WAIT.
  assign pc_load = redirect_valid && (state_q != ST_IDLE);
  assign pc_inc  = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (pc_load),
    .load_pc_i (align_pc(redirect_pc)),
    .inc_i     (pc_inc),
    .pc_o      (pc_cur)
  );

  // Fetch FSM with registered request/valid flags and the decode-side output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
        ST_REQ: begin
          // A redirect without grant just retargets the still-pending request.
          if (redirect_valid && imem_gnt) begin
            state_q <= ST_KILL;
            req_q   <= 1'b0;
          end else if (!redirect_valid && imem_gnt) begin
            state_q <= ST_WAIT;
            req_q   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            // Response arriving with the redirect is dropped; otherwise wait it out in KILL.
            state_q <= imem_rvalid ? ST_REQ : ST_KILL;
            req_q   <= imem_rvalid;
          end else if (imem_rvalid) begin
            state_q <= ST_HOLD;
            valid_q <= 1'b1;
            instr_q <= imem_rdata;
            ipc_q   <= pc_cur;
          end
        end
        ST_KILL: begin
          if (imem_rvalid) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end else if (instr_ready) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            count_q <= count_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_cur;
  assign pc          = pc_cur;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer with a delivery scoreboard.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [15:0] fetch_count;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .pc             (pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        g;
    logic        rv;
    logic        rd;
    logic        rdv;
    logic [31:0] rpc;
    logic        dlv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_ipc;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] ipc;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Memory model: remember the address of the last granted request.
  always @(posedge clk) begin
    if (imem_req && imem_gnt) mem_addr <= imem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic g, input logic rv, input logic rd, input logic rdv,
                     input logic [31:0] rpc, input logic dlv, input logic e_req,
                     input logic [31:0] e_addr, input logic e_v, input logic [31:0] e_ipc,
                     input logic [15:0] e_cnt);
    vec_t v;
    v.g = g; v.rv = rv; v.rd = rd; v.rdv = rdv; v.rpc = rpc; v.dlv = dlv;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_ipc = e_ipc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Drive one row, score any delivery happening at the coming edge, then check the row.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    imem_gnt       = v.g;
    imem_rvalid    = v.rv;
    imem_rdata     = mem_word(mem_addr);
    instr_ready    = v.rd;
    redirect_valid = v.rdv;
    redirect_pc    = v.rpc;
    if (v.dlv) begin
      e.ipc  = v.e_ipc;
      e.data = mem_word(v.e_ipc);
      sb.push_back(e);
    end
    if (instr_valid && instr_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL row%0d unexpected delivery: instr_pc %h with no expected entry", idx, instr_pc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("row%0d sb_instr_out", idx), instr_out, e.data);
        chk($sformatf("row%0d sb_instr_pc", idx), instr_pc, e.ipc);
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("row%0d imem_req", idx), {31'd0, imem_req}, {31'd0, v.e_req});
    chk($sformatf("row%0d imem_addr", idx), imem_addr, v.e_addr);
    chk($sformatf("row%0d instr_valid", idx), {31'd0, instr_valid}, {31'd0, v.e_v});
    chk($sformatf("row%0d instr_pc", idx), instr_pc, v.e_ipc);
    chk($sformatf("row%0d fetch_count", idx), {16'd0, fetch_count}, {16'd0, v.e_cnt});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, " imem_addr"}, imem_addr, 32'd0);
    chk({tag, " pc"}, pc, 32'd0);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, " instr_out"}, instr_out, 32'd0);
    chk({tag, " instr_pc"}, instr_pc, 32'd0);
    chk({tag, " fetch_count"}, {16'd0, fetch_count}, 32'd0);
  endtask

  initial begin
    //   g  rv rd rdv rpc            dlv req addr           v  ipc            cnt
    // back-to-back fetches 0,4,8,12
    add(1, 0, 1, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         0);
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         0);
    add(1, 1, 1, 0, 32'h0,         1,  0, 32'h4,         1, 32'h0,         0);
    add(1, 0, 1, 0, 32'h0,         0,  1, 32'h4,         0, 32'h0,         1);
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'h4,         0, 32'h0,         1);
    add(1, 1, 1, 0, 32'h0,         1,  0, 32'h8,         1, 32'h4,         1);
    add(1, 0, 1, 0, 32'h0,         0,  1, 32'h8,         0, 32'h4,         2);
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'h8,         0, 32'h4,         2);
    add(1, 1, 1, 0, 32'h0,         1,  0, 32'hC,         1, 32'h8,         2);
    add(1, 0, 1, 0, 32'h0,         0,  1, 32'hC,         0, 32'h8,         3);
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'hC,         0, 32'h8,         3);
    add(1, 1, 1, 0, 32'h0,         1,  0, 32'h10,        1, 32'hC,         3);
    add(1, 0, 1, 0, 32'h0,         0,  1, 32'h10,        0, 32'hC,         4);
    // decode stall in HOLD for 5 cycles, stray rvalid ignored
    add(1, 0, 0, 0, 32'h0,         0,  0, 32'h10,        0, 32'hC,         4);
    add(1, 1, 0, 0, 32'h0,         1,  0, 32'h14,        1, 32'h10,        4);
    add(1, 0, 0, 0, 32'h0,         0,  0, 32'h14,        1, 32'h10,        4);
    add(1, 1, 0, 0, 32'h0,         0,  0, 32'h14,        1, 32'h10,        4);
    add(1, 0, 0, 0, 32'h0,         0,  0, 32'h14,        1, 32'h10,        4);
    add(1, 0, 0, 0, 32'h0,         0,  0, 32'h14,        1, 32'h10,        4);
    add(1, 0, 0, 0, 32'h0,         0,  0, 32'h14,        1, 32'h10,        4);
    add(1, 0, 1, 0, 32'h0,         0,  1, 32'h14,        0, 32'h10,        5);
    // redirect to 128 in WAIT before rvalid, stale response killed
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'h14,        0, 32'h10,        5);
    add(1, 0, 1, 1, 32'd128,       0,  0, 32'd128,       0, 32'h10,        5);
    add(1, 1, 1, 0, 32'h0,         0,  1, 32'd128,       0, 32'h10,        5);
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'd128,       0, 32'h10,        5);
    add(1, 1, 1, 0, 32'h0,         1,  0, 32'd132,       1, 32'd128,       5);
    add(1, 0, 1, 0, 32'h0,         0,  1, 32'd132,       0, 32'd128,       6);
    // redirect to 0x83 in HOLD with ready=1 drops the instruction
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'd132,       0, 32'd128,       6);
    add(1, 1, 1, 0, 32'h0,         0,  0, 32'd136,       1, 32'd132,       6);
    add(1, 0, 1, 1, 32'h83,        0,  1, 32'h80,        0, 32'd132,       6);
    // REQ without grant, redirect in REQ, redirects in KILL
    add(0, 0, 1, 0, 32'h0,         0,  1, 32'h80,        0, 32'd132,       6);
    add(0, 0, 1, 1, 32'h202,       0,  1, 32'h200,       0, 32'd132,       6);
    add(1, 0, 1, 1, 32'h300,       0,  0, 32'h300,       0, 32'd132,       6);
    add(0, 0, 1, 1, 32'h400,       0,  0, 32'h400,       0, 32'd132,       6);
    add(0, 1, 1, 0, 32'h0,         0,  1, 32'h400,       0, 32'd132,       6);
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'h400,       0, 32'd132,       6);
    add(0, 1, 1, 1, 32'h500,       0,  1, 32'h500,       0, 32'd132,       6);
    // PC wrap from 0xFFFF_FFFC
    add(0, 0, 1, 1, 32'hFFFF_FFFC, 0,  1, 32'hFFFF_FFFC, 0, 32'd132,       6);
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'hFFFF_FFFC, 0, 32'd132,       6);
    add(0, 1, 1, 0, 32'h0,         1,  0, 32'h0,         1, 32'hFFFF_FFFC, 6);
    add(0, 0, 1, 0, 32'h0,         0,  1, 32'h0,         0, 32'hFFFF_FFFC, 7);
    // move to 0x40 and enter WAIT before the mid-transaction reset
    add(0, 0, 1, 1, 32'h40,        0,  1, 32'h40,        0, 32'hFFFF_FFFC, 7);
    add(1, 0, 0, 0, 32'h0,         0,  0, 32'h40,        0, 32'hFFFF_FFFC, 7);

    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("por");
    reset = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Asynchronous reset in WAIT, then a response arrives while reset is held.
    reset = 1'b0;
    #2;
    chk_reset("async_rst");
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h40);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("rst_rvalid");
    imem_rvalid = 1'b0;
    reset       = 1'b1;

    vecs.delete();
    add(0, 0, 1, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         0);
    add(1, 0, 1, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         0);
    add(0, 1, 1, 0, 32'h0,         1,  0, 32'h4,         1, 32'h0,         0);
    add(0, 0, 1, 0, 32'h0,         0,  1, 32'h4,         0, 32'h0,         1);
    foreach (vecs[i]) apply(100 + i, vecs[i]);

    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
